// File: rtl/fft_pkg.sv
// Shared FFT fixed-point helpers: Q1.(NBITS-1) constants, saturation limits and
// {re, im} pack/unpack functions used by the sequencer, twiddle multiplier and butterflies.
package fft_pkg;

  localparam int FFT_MAXW  = 32;
  localparam int FFT_W2    = 2 * FFT_MAXW;
  localparam int FFT_NBITS = 16;
  localparam int FFT_QFRAC = FFT_NBITS - 1;

  function automatic int fft_qfrac(input int nbits);
    return nbits - 1;
  endfunction

  function automatic logic signed [FFT_MAXW-1:0] fft_sat_max(input int nbits);
    logic signed [FFT_MAXW-1:0] one;
    one = 1;
    return (one <<< (nbits - 1)) - one;
  endfunction

  function automatic logic signed [FFT_MAXW-1:0] fft_sat_min(input int nbits);
    logic signed [FFT_MAXW-1:0] one;
    one = 1;
    return -(one <<< (nbits - 1));
  endfunction

  // Words are zero-extended to FFT_W2 by the caller; results come back sign-extended.
  function automatic logic signed [FFT_MAXW-1:0] fft_unpack_re(input logic [FFT_W2-1:0] w,
                                                               input int nbits);
    logic [FFT_W2-1:0] t;
    logic signed [FFT_MAXW-1:0] r;
    t = w >> nbits;
    r = t[FFT_MAXW-1:0];
    r = r <<< (FFT_MAXW - nbits);
    r = r >>> (FFT_MAXW - nbits);
    return r;
  endfunction

  function automatic logic signed [FFT_MAXW-1:0] fft_unpack_im(input logic [FFT_W2-1:0] w,
                                                               input int nbits);
    logic signed [FFT_MAXW-1:0] r;
    r = w[FFT_MAXW-1:0];
    r = r <<< (FFT_MAXW - nbits);
    r = r >>> (FFT_MAXW - nbits);
    return r;
  endfunction

  function automatic logic [FFT_W2-1:0] fft_pack(input logic [FFT_MAXW-1:0] re,
                                                 input logic [FFT_MAXW-1:0] im,
                                                 input int nbits);
    logic [FFT_W2-1:0] m;
    m = {FFT_W2{1'b1}} >> (FFT_W2 - nbits);
    return ((FFT_W2'(re) & m) << nbits) | (FFT_W2'(im) & m);
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Scales one (2*NBITS+1)-bit component back to Q1.(NBITS-1) and clamps it.
// FFT_TWIDDLE_ROUND_EN adds round-half-up before the shift; otherwise the shift truncates.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int NBITS = 16
) (
  input  logic signed [2*NBITS:0]  sum,
  output logic signed [NBITS-1:0]  q,
  output logic                     ovf
);

  localparam int W  = 2 * NBITS + 2;
  localparam int QF = fft_qfrac(NBITS);
  localparam logic signed [W-1:0] SMAX = W'(fft_sat_max(NBITS));
  localparam logic signed [W-1:0] SMIN = W'(fft_sat_min(NBITS));

  logic signed [W-1:0] ext;
  logic signed [W-1:0] sh;

  // One guard bit above the sum keeps the rounding add from wrapping.
  assign ext = W'(sum);

`ifdef FFT_TWIDDLE_ROUND_EN
  localparam logic signed [W-1:0] HALF = W'(1) <<< (QF - 1);
  assign sh = (ext + HALF) >>> QF;
`else
  assign sh = ext >>> QF;
`endif

  always_comb begin
    q   = sh[NBITS-1:0];
    ovf = 1'b0;
    if (sh > SMAX) begin
      q   = SMAX[NBITS-1:0];
      ovf = 1'b1;
    end else if (sh < SMIN) begin
      q   = SMIN[NBITS-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fft_twiddle_mult.sv
// Three-stage complex multiplier applying the twiddle to an FFT stage input stream.
// Build option FFT_TWIDDLE_ROUND_EN enables round-half-up scaling (latency unchanged).
module fft_twiddle_mult
  import fft_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int N     = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   sync_in,
  input  logic [2*NBITS-1:0]     data_in,
  input  logic [2*NBITS-1:0]     coeff_in,
  output logic                   valid_out,
  output logic [2*NBITS-1:0]     data_out,
  output logic [$clog2(N)-1:0]   idx_out,
  output logic                   last_out,
  output logic                   ovf_out
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * NBITS;
  localparam int SW = 2 * NBITS + 1;

  // Handshake: valid_in qualifies data_in/coeff_in for one cycle; there is no ready,
  // every valid beat is taken, and valid_out marks each result for exactly one cycle.

  logic [IW-1:0] cnt;
  logic [IW-1:0] tag;

  logic                    s1_v;
  logic [IW-1:0]           s1_idx;
  logic signed [NBITS-1:0] s1_a, s1_b, s1_c, s1_d;

  logic                    s2_v;
  logic [IW-1:0]           s2_idx;
  logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;

  logic signed [SW-1:0]    sum_re, sum_im;
  logic signed [NBITS-1:0] q_re, q_im;
  logic                    ovf_re, ovf_im;

  assign tag = sync_in ? '0 : cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (sync_in) begin
      cnt <= valid_in ? IW'(1) : '0;
    end else if (valid_in) begin
      cnt <= (cnt == IW'(N - 1)) ? '0 : cnt + IW'(1);
    end
  end

  // S1: capture operands and tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s1_idx <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_c   <= '0;
      s1_d   <= '0;
    end else begin
      s1_v <= valid_in;
      if (valid_in) begin
        s1_idx <= tag;
        s1_a   <= NBITS'(fft_unpack_re(FFT_W2'(data_in), NBITS));
        s1_b   <= NBITS'(fft_unpack_im(FFT_W2'(data_in), NBITS));
        s1_c   <= NBITS'(fft_unpack_re(FFT_W2'(coeff_in), NBITS));
        s1_d   <= NBITS'(fft_unpack_im(FFT_W2'(coeff_in), NBITS));
      end
    end
  end

  // S2: four partial products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v   <= 1'b0;
      s2_idx <= '0;
      p_ac   <= '0;
      p_bd   <= '0;
      p_ad   <= '0;
      p_bc   <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_idx <= s1_idx;
        p_ac   <= s1_a * s1_c;
        p_bd   <= s1_b * s1_d;
        p_ad   <= s1_a * s1_d;
        p_bc   <= s1_b * s1_c;
      end
    end
  end

  assign sum_re = SW'(p_ac) - SW'(p_bd);
  assign sum_im = SW'(p_ad) + SW'(p_bc);

  fft_round_sat #(.NBITS(NBITS)) u_rs_re (.sum(sum_re), .q(q_re), .ovf(ovf_re));
  fft_round_sat #(.NBITS(NBITS)) u_rs_im (.sum(sum_im), .q(q_im), .ovf(ovf_im));

  // S3: output registers hold their last value across idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
      idx_out   <= '0;
      ovf_out   <= 1'b0;
    end else begin
      valid_out <= s2_v;
      last_out  <= s2_v && (s2_idx == IW'(N - 1));
      if (s2_v) begin
        data_out <= PW'(fft_pack(FFT_MAXW'(q_re), FFT_MAXW'(q_im), NBITS));
        idx_out  <= s2_idx;
        ovf_out  <= ovf_re | ovf_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Directed bench for fft_twiddle_mult (NBITS=8, N=8); expected results are hand-computed
// and matched against the output stream through an expected queue.
module tb_fft_twiddle_mult;

  localparam int NBITS = 8;
  localparam int N     = 8;
  localparam int IW    = 3;
  localparam int W     = 2 * NBITS + IW + 2;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic                 sync_in;
  logic [2*NBITS-1:0]   data_in;
  logic [2*NBITS-1:0]   coeff_in;
  logic                 valid_out;
  logic [2*NBITS-1:0]   data_out;
  logic [IW-1:0]        idx_out;
  logic                 last_out;
  logic                 ovf_out;

  fft_twiddle_mult #(.NBITS(NBITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sync_in   (sync_in),
    .data_in   (data_in),
    .coeff_in  (coeff_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .idx_out   (idx_out),
    .last_out  (last_out),
    .ovf_out   (ovf_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {data, idx, last, ovf} plus the cycle each sample was driven
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] cx(input int re, input int im);
    logic [7:0] r;
    logic [7:0] i;
    r = re[7:0];
    i = im[7:0];
    return {r, i};
  endfunction

  // driver tasks
  task automatic drive(input bit v, input bit s, input logic [15:0] d, input logic [15:0] c,
                       input logic [15:0] e, input int idx, input bit ovf);
    @(posedge clk);
    #1;
    valid_in = v;
    sync_in  = s;
    data_in  = d;
    coeff_in = c;
    if (v) begin
      exp_q.push_back({e, IW'(idx), (idx == N - 1), ovf});
      lat_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, '0, 0, 1'b0);
  endtask

  logic [W-1:0] mon_e;
  int           mon_c;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(valid_out), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = lat_q.pop_front();
          check("data", 64'(data_out), 64'(mon_e[W-1:IW+2]));
          check("idx", 64'(idx_out), 64'(mon_e[IW+1:2]));
          check("last", 64'(last_out), 64'(mon_e[1]));
          check("ovf", 64'(ovf_out), 64'(mon_e[0]));
          check("latency", 64'(cyc - mon_c), 64'(3));
        end
      end else begin
        check("last_idle", 64'(last_out), 64'(0));
      end
    end
  end

  logic [15:0] rot;
  logic [15:0] exp_unity;
  logic [15:0] exp_half;

  initial begin
    rot = cx(0, -128);
`ifdef FFT_TWIDDLE_ROUND_EN
    exp_unity = cx(64, -32);
    exp_half  = cx(1, 0);
`else
    exp_unity = cx(63, -32);
    exp_half  = cx(0, 0);
`endif
    valid_in = 1'b0;
    sync_in  = 1'b0;
    data_in  = '0;
    coeff_in = '0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(valid_out), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
    check("rst_idx", 64'(idx_out), 64'(0));
    check("rst_last", 64'(last_out), 64'(0));
    check("rst_ovf", 64'(ovf_out), 64'(0));
    @(negedge clk) rst = 1'b1;

    // arithmetic vectors
    drive(1, 1, cx(64, -32), cx(127, 0), exp_unity, 0, 0);
    drive(1, 0, cx(1, 0), cx(64, 0), exp_half, 1, 0);
    drive(1, 0, cx(100, 50), rot, cx(50, -100), 2, 0);
    drive(1, 0, cx(-128, 0), cx(-128, 0), cx(127, 0), 3, 1);
    drive(1, 0, cx(-128, -128), cx(127, 127), cx(0, -128), 4, 1);
    idle(5);
    check("hold_data", 64'(data_out), 64'(cx(0, -128)));
    check("hold_idx", 64'(idx_out), 64'(4));
    check("hold_ovf", 64'(ovf_out), 64'(1));
    check("hold_valid", 64'(valid_out), 64'(0));

    // frame indexing: 10 contiguous samples, last_out only on idx 7
    for (int i = 0; i < 10; i++)
      drive(1, (i == 0), cx(i + 1, 2 * (i + 1)), rot, cx(2 * (i + 1), -(i + 1)), i % N, 0);
    idle(4);

    // gaps, mid-frame re-sync, then sync without valid
    drive(1, 1, cx(3, 4), rot, cx(4, -3), 0, 0);
    drive(0, 0, '0, '0, '0, 0, 0);
    drive(1, 0, cx(5, 6), rot, cx(6, -5), 1, 0);
    drive(1, 1, cx(7, 1), rot, cx(1, -7), 0, 0);
    drive(0, 1, '0, '0, '0, 0, 0);
    drive(1, 0, cx(9, 2), rot, cx(2, -9), 0, 0);
    idle(4);

    // asynchronous reset with samples in flight
    drive(1, 0, cx(1, 1), rot, cx(1, -1), 1, 0);
    drive(1, 0, cx(2, 2), rot, cx(2, -2), 2, 0);
    drive(1, 0, cx(3, 3), rot, cx(3, -3), 3, 0);
    @(posedge clk);
    #1 valid_in = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_out), 64'(0));
    check("midrst_data", 64'(data_out), 64'(0));
    check("midrst_idx", 64'(idx_out), 64'(0));
    check("midrst_last", 64'(last_out), 64'(0));
    check("midrst_ovf", 64'(ovf_out), 64'(0));
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    idle(4);
    drive(1, 0, cx(10, 20), rot, cx(20, -10), 0, 0);
    idle(5);

    check("drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
